// File: rtl/accel_position_filter.sv
// accel_position_filter: decimates raw signed 9-bit accelerometer X/Y samples to a
// fixed rate and box-car averages 2^LOG2_AVG samples per axis. It then subtracts a
// calibrated zero offset and saturates the result to signed 9 bits. The outputs come
// with a one-cycle filt_valid strobe.
// Build macro ACCEL_DEADZONE_EN: when defined, saturated results with
// -DEADZONE <= r <= DEADZONE are forced to zero. This adds no latency.
module accel_position_filter #(
  parameter int SAMPLE_DIV = 50000,
  parameter int LOG2_AVG   = 3,
  parameter int DEADZONE   = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic signed [8:0] raw_x,
  input  logic signed [8:0] raw_y,
  input  logic              cal_req,
  output logic signed [8:0] filt_x,
  output logic signed [8:0] filt_y,
  output logic              filt_valid,
  output logic              cal_busy
);

  localparam int ACC_W = 9 + LOG2_AVG;
  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int CNT_W = LOG2_AVG + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);

  localparam logic signed [9:0] SAT_MAX = 10'sd255;
  localparam logic signed [9:0] SAT_MIN = -10'sd256;

  localparam logic [1:0] ST_ACC  = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

`ifdef ACCEL_DEADZONE_EN
  localparam logic DZ_EN = 1'b1;
`else
  localparam logic DZ_EN = 1'b0;
`endif

  // Clamp a 10-bit signed difference into the signed 9-bit output range.
  function automatic logic signed [8:0] sat9(input logic signed [9:0] v);
    logic signed [8:0] r;
    if (v > SAT_MAX) begin
      r = 9'sh0FF;
    end else if (v < SAT_MIN) begin
      r = 9'sh100;
    end else begin
      r = 9'(v);
    end
    return r;
  endfunction

  // Force small magnitudes to zero when the dead-zone build option is enabled.
  function automatic logic signed [8:0] dz9(input logic signed [8:0] v);
    logic signed [9:0] lim;
    logic signed [9:0] ve;
    logic signed [8:0] r;
    lim = 10'(DEADZONE);
    ve  = 10'(v);
    if (DZ_EN && (ve <= lim) && (ve >= -lim)) begin
      r = 9'sd0;
    end else begin
      r = v;
    end
    return r;
  endfunction

  logic [DIV_W-1:0]        div_cnt_r;
  logic [CNT_W-1:0]        sample_cnt_r;
  logic signed [ACC_W-1:0] acc_x_r, acc_y_r;
  logic signed [8:0]       off_x_r, off_y_r;
  logic [1:0]              state_r;
  logic signed [8:0]       filt_x_r, filt_y_r;
  logic                    filt_valid_r, cal_busy_r, cal_pend_r;

  logic                    tick_s;
  logic signed [ACC_W-1:0] raw_x_ext_s, raw_y_ext_s;
  logic signed [8:0]       avg_x_s, avg_y_s, res_x_s, res_y_s;
  logic signed [9:0]       diff_x_s, diff_y_s;

  // Sample tick, window average and offset-corrected, saturated result per axis.
  always_comb begin
    tick_s      = (div_cnt_r == DIV_LAST);
    raw_x_ext_s = ACC_W'(raw_x);
    raw_y_ext_s = ACC_W'(raw_y);
    avg_x_s     = 9'(acc_x_r >>> LOG2_AVG);
    avg_y_s     = 9'(acc_y_r >>> LOG2_AVG);
    diff_x_s    = 10'(avg_x_s) - 10'(off_x_r);
    diff_y_s    = 10'(avg_y_s) - 10'(off_y_r);
    if (cal_pend_r) begin
      res_x_s = 9'sd0;
      res_y_s = 9'sd0;
    end else begin
      res_x_s = dz9(sat9(diff_x_s));
      res_y_s = dz9(sat9(diff_y_s));
    end
  end

  // Divider, accumulate/calc/output sequencing and calibration bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt_r    <= '0;
      sample_cnt_r <= '0;
      acc_x_r      <= '0;
      acc_y_r      <= '0;
      off_x_r      <= 9'sd0;
      off_y_r      <= 9'sd0;
      state_r      <= ST_ACC;
      filt_x_r     <= 9'sd0;
      filt_y_r     <= 9'sd0;
      filt_valid_r <= 1'b0;
      cal_busy_r   <= 1'b0;
      cal_pend_r   <= 1'b0;
    end else begin
      div_cnt_r    <= tick_s ? '0 : div_cnt_r + DIV_W'(1);
      filt_valid_r <= (state_r == ST_CALC);

      // A new request is only taken while idle; a pending one is consumed in CALC.
      if (cal_req && !cal_busy_r) begin
        cal_pend_r <= 1'b1;
        cal_busy_r <= 1'b1;
      end

      case (state_r)
        ST_ACC: begin
          if (tick_s) begin
            acc_x_r <= acc_x_r + raw_x_ext_s;
            acc_y_r <= acc_y_r + raw_y_ext_s;
            if (sample_cnt_r == CNT_LAST) begin
              sample_cnt_r <= '0;
              state_r      <= ST_CALC;
            end else begin
              sample_cnt_r <= sample_cnt_r + CNT_W'(1);
            end
          end
        end
        ST_CALC: begin
          if (cal_pend_r) begin
            off_x_r    <= avg_x_s;
            off_y_r    <= avg_y_s;
            cal_pend_r <= 1'b0;
            cal_busy_r <= 1'b0;
          end
          filt_x_r <= res_x_s;
          filt_y_r <= res_y_s;
          acc_x_r  <= '0;
          acc_y_r  <= '0;
          state_r  <= ST_OUT;
        end
        ST_OUT: begin
          state_r <= ST_ACC;
        end
        default: begin
          state_r <= ST_ACC;
        end
      endcase
    end
  end

  assign filt_x     = filt_x_r;
  assign filt_y     = filt_y_r;
  assign filt_valid = filt_valid_r;
  assign cal_busy   = cal_busy_r;

endmodule

// File: tb/tb_accel_position_filter.sv
// Self-checking bench for accel_position_filter (SAMPLE_DIV=4, LOG2_AVG=2, DEADZONE=4).
// Expected window results are pushed when a window's last sample is driven and are
// popped when filt_valid strobes.
module tb_accel_position_filter;

  localparam int SAMPLE_DIV = 4;
  localparam int LOG2_AVG   = 2;
  localparam int DEADZONE   = 4;
  localparam int NSAMP      = 1 << LOG2_AVG;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic signed [8:0] raw_x = 9'sd0;
  logic signed [8:0] raw_y = 9'sd0;
  logic              cal_req = 1'b0;
  logic signed [8:0] filt_x, filt_y;
  logic              filt_valid, cal_busy;

  typedef struct {
    int x;
    int y;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   first_valid_cyc = -1;
  int   off_x = 0, off_y = 0, sum_x = 0, sum_y = 0;
  bit   m_busy = 1'b0, m_cal = 1'b0;

  always #5 clock = ~clock;

  accel_position_filter #(
    .SAMPLE_DIV(SAMPLE_DIV),
    .LOG2_AVG  (LOG2_AVG),
    .DEADZONE  (DEADZONE)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .raw_x     (raw_x),
    .raw_y     (raw_y),
    .cal_req   (cal_req),
    .filt_x    (filt_x),
    .filt_y    (filt_y),
    .filt_valid(filt_valid),
    .cal_busy  (cal_busy)
  );

  task automatic check_val(input string tag, input int obs, input int expv);
    n_cmp++;
    if (obs != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int model_sat(input int v);
    if (v > 255) return 255;
    if (v < -256) return -256;
    return v;
  endfunction

  function automatic int model_dz(input int v);
`ifdef ACCEL_DEADZONE_EN
    if (v >= -DEADZONE && v <= DEADZONE) return 0;
`endif
    return v;
  endfunction

  // Output monitor: cycle count since reset and scoreboard pop on every strobe.
  always @(posedge clock) begin
    #1;
    if (reset) cyc = 0;
    else cyc = cyc + 1;
    if (filt_valid) begin
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        check_val("spurious_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("filt_x", int'(filt_x), mon_e.x);
        check_val("filt_y", int'(filt_y), mon_e.y);
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    sum_x  = 0;
    sum_y  = 0;
    off_x  = 0;
    off_y  = 0;
    m_busy = 1'b0;
    m_cal  = 1'b0;
  endtask

  // Hold one sample for a full divider period so exactly one tick absorbs it.
  task automatic drive_sample(input int x, input int y, input bit cal);
    raw_x = 9'(x);
    raw_y = 9'(y);
    sum_x += x;
    sum_y += y;
    if (cal) begin
      cal_req = 1'b1;
      if (!m_busy) begin
        m_busy = 1'b1;
        m_cal  = 1'b1;
      end
    end
    @(negedge clock);
    cal_req = 1'b0;
    check_val("cal_busy", int'(cal_busy), int'(m_busy));
    repeat (SAMPLE_DIV - 1) @(negedge clock);
  endtask

  task automatic end_window();
    int   ax, ay;
    exp_t e;
    ax = sum_x >>> LOG2_AVG;
    ay = sum_y >>> LOG2_AVG;
    if (m_cal) begin
      off_x  = ax;
      off_y  = ay;
      e.x    = 0;
      e.y    = 0;
      m_cal  = 1'b0;
      m_busy = 1'b0;
    end else begin
      e.x = model_dz(model_sat(ax - off_x));
      e.y = model_dz(model_sat(ay - off_y));
    end
    exp_q.push_back(e);
    sum_x = 0;
    sum_y = 0;
  endtask

  task automatic drive_window(input int xs[4], input int ys[4], input int cal_a, input int cal_b);
    for (int i = 0; i < NSAMP; i++) begin
      drive_sample(xs[i], ys[i], (i == cal_a) || (i == cal_b));
    end
    end_window();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_filt_x"}, int'(filt_x), 0);
    check_val({tag, "_filt_y"}, int'(filt_y), 0);
    check_val({tag, "_valid"}, int'(filt_valid), 0);
    check_val({tag, "_busy"}, int'(cal_busy), 0);
  endtask

  initial begin
    do_reset();
    check_reset_outputs("rst");

    // Constant window, then a ramp with floor rounding on the negative axis.
    drive_window('{20, 20, 20, 20}, '{-8, -8, -8, -8}, -1, -1);
    drive_window('{10, 11, 12, 13}, '{-1, -2, -2, -2}, -1, -1);
    check_val("first_valid_cycle", first_valid_cyc, 17);

    // Small values around the dead-zone boundary.
    drive_window('{3, 3, 3, 3}, '{5, 5, 5, 5}, -1, -1);
    drive_window('{4, 4, 4, 4}, '{-4, -4, -4, -4}, -1, -1);
    drive_window('{-5, -5, -5, -5}, '{-3, -3, -3, -3}, -1, -1);

    // Mid-window calibration with a second request while busy; then negative saturation.
    drive_window('{50, 50, 50, 50}, '{10, 10, 10, 10}, 1, 2);
    drive_window('{-250, -250, -250, -250}, '{10, 10, 10, 10}, -1, -1);

    // Request in the CALC cycle of the previous window applies to this window.
    drive_window('{-100, -100, -100, -100}, '{0, 0, 0, 0}, 0, -1);
    drive_window('{200, 200, 200, 200}, '{7, 7, 7, 7}, -1, -1);
    drive_window('{255, 255, 255, 255}, '{-256, -256, -256, -256}, -1, -1);

    // Reset with two samples absorbed: partial window and offset discarded.
    drive_sample(100, 100, 1'b0);
    drive_sample(100, 100, 1'b0);
    do_reset();
    check_reset_outputs("midrst");
    drive_window('{1, 2, 3, 4}, '{-9, -9, -9, -10}, -1, -1);

    for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(negedge clock);
    check_val("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
